// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode-side issue handshake and pipeline status bundle
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int SEL_W  = 2
);
  logic              issue_valid;
  logic [REG_AW-1:0] issue_ra;
  logic [REG_AW-1:0] issue_rb;
  logic              issue_ra_en;
  logic              issue_rb_en;
  logic [REG_AW-1:0] issue_wd;
  logic              issue_wd_en;
  logic              issue_is_load;
  logic              flush;
  logic              issue_ready;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic [SEL_W-1:0]  inflight;
  logic [15:0]       stall_cnt;
  modport master (
    output issue_valid, issue_ra, issue_rb, issue_ra_en, issue_rb_en,
           issue_wd, issue_wd_en, issue_is_load, flush,
    input  issue_ready, fwd_sel_a, fwd_sel_b, wb_valid, wb_addr, inflight, stall_cnt
  );
  modport slave (
    input  issue_valid, issue_ra, issue_rb, issue_ra_en, issue_rb_en,
           issue_wd, issue_wd_en, issue_is_load, flush,
    output issue_ready, fwd_sel_a, fwd_sel_b, wb_valid, wb_addr, inflight, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW hazard stall, forwarding select and branch flush for an N-stage pipe
module pipe_hazard_ctrl #(
  parameter int STAGES    = 3,
  parameter int REG_AW    = 3,
  parameter int FWD_EN    = 1,
  parameter int LOAD_SLOT = STAGES - 1,
  parameter int BR_SLOT   = 1
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int SEL_W = (STAGES > 2) ? $clog2(STAGES) : 1;
  localparam int N = STAGES - 1;
  logic              vld_q [1:N];
  logic              vld_d [1:N];
  logic              wen_q [1:N];
  logic              wen_d [1:N];
  logic              ld_q  [1:N];
  logic              ld_d  [1:N];
  logic [REG_AW-1:0] wd_q  [1:N];
  logic [REG_AW-1:0] wd_d  [1:N];
  logic              fok   [1:N];
  logic [15:0]       cnt_q, cnt_d;
  logic              haz_a, haz_b, ready;
  logic [SEL_W-1:0]  sel_a, sel_b, occ;
  // a producer in slot k can feed the operand muxes unless it is a load not yet returned
  always_comb
    for (int k = 1; k <= N; k++) fok[k] = (FWD_EN != 0) && (!ld_q[k] || k >= LOAD_SLOT);
  // scan oldest to youngest so the last hit is the youngest producer
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (bus.issue_ra_en && vld_q[k] && wen_q[k] && wd_q[k] == bus.issue_ra) begin
        sel_a = fok[k] ? SEL_W'(k) : '0;
        haz_a = !fok[k];
      end
      if (bus.issue_rb_en && vld_q[k] && wen_q[k] && wd_q[k] == bus.issue_rb) begin
        sel_b = fok[k] ? SEL_W'(k) : '0;
        haz_b = !fok[k];
      end
    end
  end
  assign ready = rst_n && bus.issue_valid && !haz_a && !haz_b && !bus.flush;
  // advance every slot by one; a flush kills the wrong-path slots younger than the branch
  always_comb begin
    vld_d[1] = ready;
    wen_d[1] = bus.issue_wd_en;
    wd_d[1]  = bus.issue_wd;
    ld_d[1]  = bus.issue_is_load;
    for (int k = 2; k <= N; k++) begin
      vld_d[k] = vld_q[k-1] && !(bus.flush && (k - 1) < BR_SLOT);
      wen_d[k] = wen_q[k-1];
      wd_d[k]  = wd_q[k-1];
      ld_d[k]  = ld_q[k-1];
    end
    cnt_d = (bus.issue_valid && (haz_a || haz_b) && !bus.flush && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  // popcount of occupied slots
  always_comb begin
    occ = '0;
    for (int k = 1; k <= N; k++) occ = occ + SEL_W'(vld_q[k]);
  end
  // slot storage and stall counter; reset drops all in-flight work without retiring it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q <= '{default: 1'b0};
      wen_q <= '{default: 1'b0};
      ld_q  <= '{default: 1'b0};
      wd_q  <= '{default: '0};
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      wen_q <= wen_d;
      ld_q  <= ld_d;
      wd_q  <= wd_d;
      cnt_q <= cnt_d;
    end
  assign bus.issue_ready = ready;
  assign bus.fwd_sel_a   = sel_a;
  assign bus.fwd_sel_b   = sel_b;
  assign bus.wb_valid    = vld_q[N] && wen_q[N];
  assign bus.wb_addr     = wd_q[N];
  assign bus.inflight    = occ;
  assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus random issue streams against a timestamp model
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic iv, rae, rbe, wde, ld, fl;
  logic [2:0] ra, rb, wd;
  int checks = 0;
  int errors = 0;
  pipe_hazard_ctrl_if #(.REG_AW(3), .SEL_W(2)) b0 ();
  pipe_hazard_ctrl_if #(.REG_AW(3), .SEL_W(2)) b1 ();
  pipe_hazard_ctrl_if #(.REG_AW(3), .SEL_W(2)) b2 ();
  assign {b0.issue_valid, b0.issue_ra, b0.issue_ra_en, b0.issue_rb, b0.issue_rb_en, b0.issue_wd, b0.issue_wd_en, b0.issue_is_load, b0.flush} = {iv, ra, rae, rb, rbe, wd, wde, ld, fl};
  assign {b1.issue_valid, b1.issue_ra, b1.issue_ra_en, b1.issue_rb, b1.issue_rb_en, b1.issue_wd, b1.issue_wd_en, b1.issue_is_load, b1.flush} = {iv, ra, rae, rb, rbe, wd, wde, ld, fl};
  assign {b2.issue_valid, b2.issue_ra, b2.issue_ra_en, b2.issue_rb, b2.issue_rb_en, b2.issue_wd, b2.issue_wd_en, b2.issue_is_load, b2.flush} = {iv, ra, rae, rb, rbe, wd, wde, ld, fl};
  pipe_hazard_ctrl #(.STAGES(3), .REG_AW(3), .FWD_EN(1), .LOAD_SLOT(2), .BR_SLOT(1)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  pipe_hazard_ctrl #(.STAGES(3), .REG_AW(3), .FWD_EN(0), .LOAD_SLOT(2), .BR_SLOT(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  pipe_hazard_ctrl #(.STAGES(4), .REG_AW(3), .FWD_EN(1), .LOAD_SLOT(3), .BR_SLOT(2)) d2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  logic rdy [3];
  logic wbv [3];
  logic [1:0] sa [3];
  logic [1:0] sb [3];
  logic [1:0] inf [3];
  logic [2:0] wba [3];
  logic [15:0] sc [3];
  always_comb begin
    rdy = '{b0.issue_ready, b1.issue_ready, b2.issue_ready};
    wbv = '{b0.wb_valid, b1.wb_valid, b2.wb_valid};
    sa  = '{b0.fwd_sel_a, b1.fwd_sel_a, b2.fwd_sel_a};
    sb  = '{b0.fwd_sel_b, b1.fwd_sel_b, b2.fwd_sel_b};
    inf = '{b0.inflight, b1.inflight, b2.inflight};
    wba = '{b0.wb_addr, b1.wb_addr, b2.wb_addr};
    sc  = '{b0.stall_cnt, b1.stall_cnt, b2.stall_cnt};
  end
  int p_st [3] = '{3, 3, 4};
  int p_fw [3] = '{1, 0, 1};
  int p_ls [3] = '{2, 2, 3};
  int p_br [3] = '{1, 1, 2};
  // model history: what each instance accepted in absolute cycle c, stored at c mod 16
  bit mv [3][16];
  bit mwe [3][16];
  bit mld [3][16];
  logic [2:0] mwd [3][16];
  int mcnt [3];
  int n;
  task automatic drive(input logic v, input logic [2:0] a, input logic ae, input logic [2:0] b, input logic be,
                       input logic [2:0] w, input logic we, input logic l, input logic f);
    iv = v; ra = a; rae = ae; rb = b; rbe = be; wd = w; wde = we; ld = l; fl = f;
    #1;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++; if (rdy[d] !== 1'b0) begin errors++; $display("FAIL reset_ready dut%0d: got %0b expected 0", d, rdy[d]); end
      checks++; if (wbv[d] !== 1'b0) begin errors++; $display("FAIL reset_wb_valid dut%0d: got %0b expected 0", d, wbv[d]); end
      checks++; if (inf[d] !== 2'd0) begin errors++; $display("FAIL reset_inflight dut%0d: got %0d expected 0", d, inf[d]); end
      checks++; if (sc[d] !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt dut%0d: got %0d expected 0", d, sc[d]); end
    end
  endtask
  task automatic test_alu_chain();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL alu_t0_ready: got %0b expected 1", rdy[0]); end
    @(negedge clk); drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL alu_t1_ready: got %0b expected 1", rdy[0]); end
    checks++; if (sa[0] !== 2'd1) begin errors++; $display("FAIL alu_t1_sel_a: got %0d expected 1", sa[0]); end
    @(negedge clk); drive(1, 0, 0, 3, 1, 0, 0, 0, 0);
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL alu_t2_ready: got %0b expected 1", rdy[0]); end
    checks++; if (sb[0] !== 2'd2) begin errors++; $display("FAIL alu_t2_sel_b: got %0d expected 2", sb[0]); end
    @(negedge clk); drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL alu_t3_ready: got %0b expected 1", rdy[0]); end
    checks++; if (sa[0] !== 2'd0) begin errors++; $display("FAIL alu_t3_sel_a: got %0d expected 0", sa[0]); end
  endtask
  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL load_t0_ready: got %0b expected 1", rdy[0]); end
    @(negedge clk); drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL load_t1_ready: got %0b expected 0", rdy[0]); end
    @(negedge clk); drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (sc[0] !== 16'd1) begin errors++; $display("FAIL load_stall_cnt: got %0d expected 1", sc[0]); end
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL load_t2_ready: got %0b expected 1", rdy[0]); end
    checks++; if (sa[0] !== 2'd2) begin errors++; $display("FAIL load_t2_sel_a: got %0d expected 2", sa[0]); end
  endtask
  task automatic test_youngest();
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
    @(negedge clk); drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL young_ready: got %0b expected 1", rdy[0]); end
    checks++; if (sa[0] !== 2'd1) begin errors++; $display("FAIL young_sel_a: got %0d expected 1", sa[0]); end
  endtask
  task automatic test_no_fwd();
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
    checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL nofwd_t0_ready: got %0b expected 1", rdy[1]); end
    @(negedge clk); drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL nofwd_t1_ready: got %0b expected 0", rdy[1]); end
    @(negedge clk); drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL nofwd_t2_ready: got %0b expected 0", rdy[1]); end
    @(negedge clk); drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL nofwd_t3_ready: got %0b expected 1", rdy[1]); end
    checks++; if (sa[1] !== 2'd0) begin errors++; $display("FAIL nofwd_t3_sel_a: got %0d expected 0", sa[1]); end
    checks++; if (sc[1] !== 16'd2) begin errors++; $display("FAIL nofwd_stall_cnt: got %0d expected 2", sc[1]); end
  endtask
  task automatic test_flush();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    checks++; if (rdy[2] !== 1'b1) begin errors++; $display("FAIL flush_t0_ready: got %0b expected 1", rdy[2]); end
    @(negedge clk); drive(1, 0, 0, 0, 0, 6, 1, 0, 0);
    checks++; if (rdy[2] !== 1'b1) begin errors++; $display("FAIL flush_t1_ready: got %0b expected 1", rdy[2]); end
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (rdy[2] !== 1'b0) begin errors++; $display("FAIL flush_t2_ready: got %0b expected 0", rdy[2]); end
    @(negedge clk); drive(1, 6, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (inf[2] !== 2'd1) begin errors++; $display("FAIL flush_inflight: got %0d expected 1", inf[2]); end
    checks++; if (wbv[2] !== 1'b1 || wba[2] !== 3'd1) begin errors++; $display("FAIL flush_older_kept: got valid=%0b addr=%0d expected valid=1 addr=1", wbv[2], wba[2]); end
    checks++; if (rdy[2] !== 1'b1) begin errors++; $display("FAIL flush_reader_ready: got %0b expected 1", rdy[2]); end
    checks++; if (sa[2] !== 2'd0) begin errors++; $display("FAIL flush_reader_sel_a: got %0d expected 0", sa[2]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (wbv[2] !== 1'b0) begin errors++; $display("FAIL flush_no_wb cycle%0d: got valid=%0b addr=%0d expected valid=0", i, wbv[2], wba[2]); end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
      @(negedge clk); drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk); drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (inf[0] !== 2'd2) begin errors++; $display("FAIL rstmid_pre_inflight: got %0d expected 2", inf[0]); end
    checks++; if (sc[0] !== 16'd5) begin errors++; $display("FAIL rstmid_pre_stall_cnt: got %0d expected 5", sc[0]); end
    checks++; if (wbv[0] !== 1'b1 || wba[0] !== 3'd7) begin errors++; $display("FAIL rstmid_pre_wb: got valid=%0b addr=%0d expected valid=1 addr=7", wbv[0], wba[0]); end
    rst_n = 1'b0;
    #1;
    checks++; if (wbv[0] !== 1'b0) begin errors++; $display("FAIL rstmid_wb_valid: got %0b expected 0", wbv[0]); end
    checks++; if (inf[0] !== 2'd0) begin errors++; $display("FAIL rstmid_inflight: got %0d expected 0", inf[0]); end
    checks++; if (sc[0] !== 16'd0) begin errors++; $display("FAIL rstmid_stall_cnt: got %0d expected 0", sc[0]); end
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %0b expected 0", rdy[0]); end
    @(negedge clk); rst_n = 1'b1; drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready: got %0b expected 1", rdy[0]); end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (inf[0] !== 2'd1) begin errors++; $display("FAIL rstmid_release_inflight: got %0d expected 1", inf[0]); end
  endtask
  task automatic test_random();
    int e_sa, e_sb, e_inf, idx;
    bit e_ha, e_hb, e_rdy, e_wbv, fa, fb;
    logic [2:0] e_wba;
    do_reset();
    n = 16;
    for (int d = 0; d < 3; d++) begin
      mcnt[d] = 0;
      for (int j = 0; j < 16; j++) mv[d][j] = 1'b0;
    end
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
            3'($urandom_range(0, 3)), $urandom_range(0, 1) != 0, 3'($urandom_range(0, 3)),
            $urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      for (int d = 0; d < 3; d++) begin
        e_sa = 0; e_sb = 0; e_ha = 0; e_hb = 0; fa = 0; fb = 0; e_inf = 0;
        for (int k = 1; k < p_st[d]; k++) begin
          idx = (n - k) & 15;
          if (mv[d][idx]) e_inf++;
          if (!fa && rae && mv[d][idx] && mwe[d][idx] && mwd[d][idx] == ra) begin
            fa = 1;
            if (p_fw[d] == 1 && (!mld[d][idx] || k >= p_ls[d])) e_sa = k; else e_ha = 1;
          end
          if (!fb && rbe && mv[d][idx] && mwe[d][idx] && mwd[d][idx] == rb) begin
            fb = 1;
            if (p_fw[d] == 1 && (!mld[d][idx] || k >= p_ls[d])) e_sb = k; else e_hb = 1;
          end
        end
        e_rdy = iv && !e_ha && !e_hb && !fl;
        idx = (n - (p_st[d] - 1)) & 15;
        e_wbv = mv[d][idx] && mwe[d][idx];
        e_wba = mwd[d][idx];
        checks++; if (rdy[d] !== e_rdy) begin errors++; $display("FAIL rand_ready dut%0d cyc%0d: got %0b expected %0b", d, c, rdy[d], e_rdy); end
        if (e_rdy) begin
          checks++; if (sa[d] !== 2'(e_sa)) begin errors++; $display("FAIL rand_sel_a dut%0d cyc%0d: got %0d expected %0d", d, c, sa[d], e_sa); end
          checks++; if (sb[d] !== 2'(e_sb)) begin errors++; $display("FAIL rand_sel_b dut%0d cyc%0d: got %0d expected %0d", d, c, sb[d], e_sb); end
        end
        checks++; if (inf[d] !== 2'(e_inf)) begin errors++; $display("FAIL rand_inflight dut%0d cyc%0d: got %0d expected %0d", d, c, inf[d], e_inf); end
        checks++; if (wbv[d] !== e_wbv) begin errors++; $display("FAIL rand_wb_valid dut%0d cyc%0d: got %0b expected %0b", d, c, wbv[d], e_wbv); end
        if (e_wbv) begin
          checks++; if (wba[d] !== e_wba) begin errors++; $display("FAIL rand_wb_addr dut%0d cyc%0d: got %0d expected %0d", d, c, wba[d], e_wba); end
        end
        checks++; if (sc[d] !== 16'(mcnt[d])) begin errors++; $display("FAIL rand_stall_cnt dut%0d cyc%0d: got %0d expected %0d", d, c, sc[d], mcnt[d]); end
        if (iv && (e_ha || e_hb) && !fl && mcnt[d] < 65535) mcnt[d]++;
        if (fl) for (int k = 1; k < p_br[d]; k++) mv[d][(n - k) & 15] = 1'b0;
        mv[d][n & 15] = e_rdy;
        mwe[d][n & 15] = wde;
        mwd[d][n & 15] = wd;
        mld[d][n & 15] = ld;
      end
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_no_fwd();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
